// File: rtl/vram_arb_pkg.sv
// Shared widths and the access-owner tag used by the VRAM arbiter and its helpers.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of video-fetch, CPU-access and single-port RAM signals around the arbiter.
interface vram_arbiter_if;
  import vram_arb_pkg::*;

  logic                   vid_req;
  logic [VRAM_ADDR_W-1:0] vid_addr;
  logic [VRAM_DATA_W-1:0] vid_data;
  logic                   vid_valid;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [VRAM_ADDR_W-1:0] cpu_addr;
  logic [VRAM_DATA_W-1:0] cpu_wdata;
  logic [VRAM_DATA_W-1:0] cpu_rdata;
  logic                   cpu_ack;

  logic [VRAM_ADDR_W-1:0] ram_addr;
  logic [VRAM_DATA_W-1:0] ram_wdata;
  logic                   ram_we;
  logic [VRAM_DATA_W-1:0] ram_q;

  logic                   starve_err;

  // Arbiter side.
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
    output vid_data, vid_valid, cpu_rdata, cpu_ack, ram_addr, ram_wdata, ram_we,
           starve_err
  );

  // Client / RAM side.
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
    input  vid_data, vid_valid, cpu_rdata, cpu_ack, ram_addr, ram_wdata, ram_we,
           starve_err
  );

endinterface

// File: rtl/vram_starve_mon.sv
// Counts cycles a ready CPU request is passed over and latches a sticky starvation flag.
module vram_starve_mon #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic clk_25,
  input  logic reset,
  input  logic i_cpu_req,
  input  logic i_cpu_busy,
  input  logic i_grant,
  output logic o_starve_err
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [7:0] r_wait_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_waiting;
  logic       r_starve;

  assign w_waiting = i_cpu_req && !i_cpu_busy && !i_grant;

  always_comb begin
    w_cnt_nxt = r_wait_cnt;
    if (i_grant)
      w_cnt_nxt = '0;
    else if (w_waiting && (r_wait_cnt != 8'hFF))
      w_cnt_nxt = r_wait_cnt + 8'd1;
  end

  // Flag is set on the same edge the count reaches the limit, so it is visible the next cycle.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_starve   <= 1'b0;
    end else begin
      r_wait_cnt <= w_cnt_nxt;
      if (w_cnt_nxt >= LIMIT)
        r_starve <= 1'b1;
    end
  end

  assign o_starve_err = r_starve;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads have absolute priority, CPU gets leftover slots.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int WAIT_LIMIT = 8
) (
  input logic           clk_25,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  logic                   w_vid_issue;
  logic                   w_cpu_grant;
  logic                   w_starve_err;

  logic                   r_cpu_busy;
  owner_t                 r_tag_p0;
  owner_t                 r_tag_p1;
  logic                   r_wr_p0;
  logic                   r_wr_p1;

  logic [VRAM_ADDR_W-1:0] r_ram_addr;
  logic [VRAM_DATA_W-1:0] r_ram_wdata;
  logic                   r_ram_we;
  logic [VRAM_DATA_W-1:0] r_vid_data;
  logic                   r_vid_valid;
  logic [VRAM_DATA_W-1:0] r_cpu_rdata;
  logic                   r_cpu_ack;

  assign w_vid_issue = bus.vid_req;
  assign w_cpu_grant = bus.cpu_req && !bus.vid_req && !r_cpu_busy;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_cpu_busy  <= 1'b0;
      r_tag_p0    <= OWN_NONE;
      r_tag_p1    <= OWN_NONE;
      r_wr_p0     <= 1'b0;
      r_wr_p1     <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_ram_we    <= 1'b0;
      r_vid_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;

      // Issue: register RAM controls and tag the slot owner (p0 = address on the RAM).
      if (w_vid_issue) begin
        r_ram_addr <= bus.vid_addr;
        r_tag_p0   <= OWN_VID;
        r_wr_p0    <= 1'b0;
      end else if (w_cpu_grant) begin
        r_ram_addr  <= bus.cpu_addr;
        r_ram_wdata <= bus.cpu_wdata;
        r_ram_we    <= bus.cpu_we;
        r_tag_p0    <= OWN_CPU;
        r_wr_p0     <= bus.cpu_we;
      end else begin
        r_tag_p0 <= OWN_NONE;
        r_wr_p0  <= 1'b0;
      end

      // p1: RAM data valid on ram_q this cycle.
      r_tag_p1 <= r_tag_p0;
      r_wr_p1  <= r_wr_p0;

      // Return: route ram_q to its owner.
      case (r_tag_p1)
        OWN_VID: begin
          r_vid_data  <= bus.ram_q;
          r_vid_valid <= 1'b1;
        end
        OWN_CPU: begin
          r_cpu_ack <= 1'b1;
          if (!r_wr_p1)
            r_cpu_rdata <= bus.ram_q;
        end
        default: ;
      endcase

      // Busy spans grant through the ack cycle, blocking a re-grant while ack is visible.
      if (w_cpu_grant)
        r_cpu_busy <= 1'b1;
      else if (r_cpu_ack)
        r_cpu_busy <= 1'b0;
    end
  end

  vram_starve_mon #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_starve_mon (
    .clk_25       (clk_25),
    .reset        (reset),
    .i_cpu_req    (bus.cpu_req),
    .i_cpu_busy   (r_cpu_busy),
    .i_grant      (w_cpu_grant),
    .o_starve_err (w_starve_err)
  );

  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.ram_we     = r_ram_we;
  assign bus.vid_data   = r_vid_data;
  assign bus.vid_valid  = r_vid_valid;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.starve_err = w_starve_err;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_vram_arbiter;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  logic r_preload = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] mem [0:8191];

  vram_arbiter_if bus();

  vram_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus)
  );

  always #20 clk_25 = ~clk_25;

  // Synchronous single-port RAM: q valid one cycle after the address is presented.
  always @(posedge clk_25) begin
    if (r_preload) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[13'h0123] <= 8'h5A;
      mem[13'h0200] <= 8'h11;
      mem[13'h0201] <= 8'h22;
      mem[13'h0202] <= 8'h33;
      mem[13'h0300] <= 8'h77;
      bus.ram_q     <= 8'h00;
    end else begin
      bus.ram_q <= mem[bus.ram_addr];
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  typedef struct {
    logic        vreq;
    logic [12:0] vaddr;
    logic        creq;
    logic        cwe;
    logic [12:0] caddr;
    logic [7:0]  cwd;
    logic [12:0] e_addr;
    logic        e_we;
    logic        e_vv;
    logic [7:0]  e_vd;
    logic        e_ack;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [21];

  task automatic step();
    @(posedge clk_25);
    @(negedge clk_25);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ram_we"},     32'(bus.ram_we),     32'h0);
    check({tag, " ram_addr"},   32'(bus.ram_addr),   32'h0);
    check({tag, " ram_wdata"},  32'(bus.ram_wdata),  32'h0);
    check({tag, " vid_data"},   32'(bus.vid_data),   32'h0);
    check({tag, " vid_valid"},  32'(bus.vid_valid),  32'h0);
    check({tag, " cpu_rdata"},  32'(bus.cpu_rdata),  32'h0);
    check({tag, " cpu_ack"},    32'(bus.cpu_ack),    32'h0);
    check({tag, " starve_err"}, 32'(bus.starve_err), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_reset_outputs(tag);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            vreq vaddr      creq cwe caddr     cwd    e_addr    we vv e_vd   ack e_rd
    tbl[0]  = '{1'b1, 13'h0123, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0123, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0123, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h1FFF, 8'hC3, 13'h0123, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h1FFF, 8'hC3, 13'h1FFF, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h1FFF, 8'hC3, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 13'h0000, 1'b1, 1'b1, 13'h1FFF, 8'hC3, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 13'h0000, 1'b1, 1'b0, 13'h1FFF, 8'h00, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 13'h0000, 1'b1, 1'b0, 13'h1FFF, 8'h00, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 13'h0000, 1'b1, 1'b0, 13'h1FFF, 8'h00, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 13'h0000, 1'b1, 1'b0, 13'h1FFF, 8'h00, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b1, 8'hC3};
    tbl[12] = '{1'b1, 13'h0200, 1'b1, 1'b0, 13'h0300, 8'h00, 13'h1FFF, 1'b0, 1'b0, 8'h5A, 1'b0, 8'hC3};
    tbl[13] = '{1'b0, 13'h0000, 1'b1, 1'b0, 13'h0300, 8'h00, 13'h0200, 1'b0, 1'b0, 8'h5A, 1'b0, 8'hC3};
    tbl[14] = '{1'b1, 13'h0201, 1'b1, 1'b0, 13'h0300, 8'h00, 13'h0300, 1'b0, 1'b0, 8'h5A, 1'b0, 8'hC3};
    tbl[15] = '{1'b1, 13'h0202, 1'b1, 1'b0, 13'h0300, 8'h00, 13'h0201, 1'b0, 1'b1, 8'h11, 1'b0, 8'hC3};
    tbl[16] = '{1'b1, 13'h0123, 1'b1, 1'b0, 13'h0300, 8'h00, 13'h0202, 1'b0, 1'b0, 8'h11, 1'b1, 8'h77};
    tbl[17] = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0123, 1'b0, 1'b1, 8'h22, 1'b0, 8'h77};
    tbl[18] = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0123, 1'b0, 1'b1, 8'h33, 1'b0, 8'h77};
    tbl[19] = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0123, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h77};
    tbl[20] = '{1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 13'h0123, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h77};

    idle_inputs();
    @(negedge clk_25);
    step();
    r_preload = 1'b0;
    do_reset("reset0");

    // Per-cycle vectors: check outputs of this cycle, then drive this cycle's inputs.
    for (int i = 0; i < 21; i++) begin
      check($sformatf("row%0d ram_addr", i),   32'(bus.ram_addr),   32'(tbl[i].e_addr));
      check($sformatf("row%0d ram_we", i),     32'(bus.ram_we),     32'(tbl[i].e_we));
      check($sformatf("row%0d vid_valid", i),  32'(bus.vid_valid),  32'(tbl[i].e_vv));
      check($sformatf("row%0d vid_data", i),   32'(bus.vid_data),   32'(tbl[i].e_vd));
      check($sformatf("row%0d cpu_ack", i),    32'(bus.cpu_ack),    32'(tbl[i].e_ack));
      check($sformatf("row%0d cpu_rdata", i),  32'(bus.cpu_rdata),  32'(tbl[i].e_rd));
      check($sformatf("row%0d starve_err", i), 32'(bus.starve_err), 32'h0);
      bus.vid_req   = tbl[i].vreq;
      bus.vid_addr  = tbl[i].vaddr;
      bus.cpu_req   = tbl[i].creq;
      bus.cpu_we    = tbl[i].cwe;
      bus.cpu_addr  = tbl[i].caddr;
      bus.cpu_wdata = tbl[i].cwd;
      step();
    end

    // Starvation: video holds the RAM for 6 cycles while a CPU read waits.
    do_reset("reset1");
    for (int k = 0; k < 6; k++) begin
      check($sformatf("starve s%0d starve_err", k), 32'(bus.starve_err), (k >= 4) ? 32'h1 : 32'h0);
      check($sformatf("starve s%0d cpu_ack", k), 32'(bus.cpu_ack), 32'h0);
      bus.vid_req  = 1'b1;
      bus.vid_addr = 13'h0010 + 13'(k);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 13'h0300;
      step();
    end
    check("starve s6 starve_err", 32'(bus.starve_err), 32'h1);
    bus.vid_req = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.cpu_ack && n < 8);
    check("starve cpu_ack seen", 32'(bus.cpu_ack), 32'h1);
    check("starve ack latency", 32'(n), 32'd3);
    check("starve cpu_rdata", 32'(bus.cpu_rdata), 32'h77);
    bus.cpu_req = 1'b0;
    repeat (4) step();
    check("starve sticky", 32'(bus.starve_err), 32'h1);

    // Reset in the cycle after a CPU read is issued discards the return.
    do_reset("reset2");
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 13'h0300;
    step();
    check("midrst issued addr", 32'(bus.ram_addr), 32'h0300);
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    check_reset_outputs("midrst");
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("midrst +%0d cpu_ack", k), 32'(bus.cpu_ack), 32'h0);
      check($sformatf("midrst +%0d cpu_rdata", k), 32'(bus.cpu_rdata), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
